// File: rtl/trdb_pkg.sv
// Shared trace-debug definitions: E-trace itype codes, opcode mask/match pairs
// and link-register helpers used by the decoder and the classifier.
package trdb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        NONE       = 4'd0,
        EXC        = 4'd1,
        INT        = 4'd2,
        ERET       = 4'd3,
        NT_BR      = 4'd4,
        T_BR       = 4'd5,
        UNINF_JMP6 = 4'd6,
        UNINF_CALL = 4'd8,
        INF_CALL   = 4'd9,
        UNINF_JMP  = 4'd10,
        INF_JMP    = 4'd11,
        RET        = 4'd13
    } itype_e;

    localparam logic [31:0] MASK_OPCODE  = 32'h0000_007F;
    localparam logic [31:0] MATCH_BRANCH = 32'h0000_0063;
    localparam logic [31:0] MATCH_JAL    = 32'h0000_006F;
    localparam logic [31:0] MASK_JALR    = 32'h0000_707F;
    localparam logic [31:0] MATCH_JALR   = 32'h0000_0067;
    localparam logic [31:0] MATCH_MRET   = 32'h3020_0073;
    localparam logic [31:0] MATCH_SRET   = 32'h1020_0073;
    localparam logic [31:0] MATCH_URET   = 32'h0020_0073;
    localparam logic [31:0] MATCH_DRET   = 32'h7B20_0073;

    localparam logic [15:0] MASK_C_CJ    = 16'hE003;
    localparam logic [15:0] MATCH_C_J    = 16'hA001;
    localparam logic [15:0] MATCH_C_JAL  = 16'h2001;
    localparam logic [15:0] MATCH_C_BEQZ = 16'hC001;
    localparam logic [15:0] MATCH_C_BNEZ = 16'hE001;
    localparam logic [15:0] MASK_C_JR    = 16'hF07F;
    localparam logic [15:0] MATCH_C_JR   = 16'h8002;
    localparam logic [15:0] MATCH_C_JALR = 16'h9002;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

    function automatic logic is_updiscon(input itype_e t);
        return t inside {EXC, INT, ERET, UNINF_JMP6, UNINF_CALL, UNINF_JMP, RET};
    endfunction

endpackage

// File: rtl/trdb_inst_decoder.sv
// Combinational control-flow decoder: classifies one retired encoding (32-bit
// or compressed) into branch / jump / call / return / xRET flags.
module trdb_inst_decoder (
    input  logic [31:0] inst_i,
    input  logic        compressed_i,
    output logic        is_branch_o,
    output logic        is_jal_o,
    output logic        is_jalr_o,
    output logic        is_call_o,
    output logic        is_ret_o,
    output logic        is_xret_o
);
    import trdb_pkg::*;

    logic [15:0] w_c;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;

    assign w_c = inst_i[15:0];

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        is_branch_o = 1'b0;
        is_jal_o    = 1'b0;
        is_jalr_o   = 1'b0;
        is_xret_o   = 1'b0;
        w_rd        = REG_X0;
        w_rs1       = REG_X0;
        if (compressed_i) begin
            is_branch_o = ((w_c & MASK_C_CJ) == MATCH_C_BEQZ) || ((w_c & MASK_C_CJ) == MATCH_C_BNEZ);
            if ((w_c & MASK_C_CJ) == MATCH_C_J) begin
                is_jal_o = 1'b1;
            end
            if ((w_c & MASK_C_CJ) == MATCH_C_JAL) begin
                is_jal_o = 1'b1;
                w_rd     = REG_RA;
            end
            // rs1 == x0 in these slots encodes C.EBREAK / reserved, not a jump
            if (((w_c & MASK_C_JR) == MATCH_C_JR) && (w_c[11:7] != REG_X0)) begin
                is_jalr_o = 1'b1;
                w_rs1     = w_c[11:7];
            end
            if (((w_c & MASK_C_JR) == MATCH_C_JALR) && (w_c[11:7] != REG_X0)) begin
                is_jalr_o = 1'b1;
                w_rd      = REG_RA;
                w_rs1     = w_c[11:7];
            end
        end else begin
            w_rd        = inst_i[11:7];
            w_rs1       = inst_i[19:15];
            is_branch_o = (inst_i & MASK_OPCODE) == MATCH_BRANCH;
            is_jal_o    = (inst_i & MASK_OPCODE) == MATCH_JAL;
            is_jalr_o   = (inst_i & MASK_JALR) == MATCH_JALR;
            is_xret_o   = inst_i inside {MATCH_MRET, MATCH_SRET, MATCH_URET, MATCH_DRET};
        end
        is_call_o = (is_jal_o || is_jalr_o) && is_link(w_rd);
        is_ret_o  = is_jalr_o && (w_rd == REG_X0) && is_link(w_rs1) && (w_rs1 != w_rd);
    end

endmodule

// File: rtl/trdb_itype_classifier.sv
// Holds one retired instruction (tc) until its successor (nc) retires or a flush
// drains it, then emits the E-trace itype with call-nesting implicit-return hints.
module trdb_itype_classifier #(
    parameter int XLEN         = trdb_pkg::XLEN,
    parameter int ITYPE_W      = 4,
    parameter int CALL_CNT_W   = 4,
    parameter bit IMPLICIT_RET = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               inst_valid_i,
    input  logic [XLEN-1:0]    iaddr_i,
    input  logic [XLEN-1:0]    inst_data_i,
    input  logic               compressed_i,
    input  logic               exception_i,
    input  logic               interrupt_i,
    input  logic               flush_i,
    output logic               valid_o,
    output logic [XLEN-1:0]    iaddr_o,
    output logic [ITYPE_W-1:0] itype_o,
    output logic               ilastsize_o,
    output logic               updiscon_o,
    output logic               implicit_ret_o,
    output logic               flushed_o
);
    import trdb_pkg::*;

    logic                  r_pend, r_drain;
    logic [XLEN-1:0]       r_tc_iaddr;
    logic [31:0]           r_tc_inst;
    logic                  r_tc_comp, r_tc_exc, r_tc_int;
    logic [CALL_CNT_W-1:0] r_call_cnt;
    logic                  r_valid, r_ilastsize, r_updiscon, r_implicit, r_flushed;
    logic [XLEN-1:0]       r_iaddr;
    logic [ITYPE_W-1:0]    r_itype;

    logic w_is_branch, w_is_jal, w_is_jalr, w_is_call, w_is_ret, w_is_xret;
    logic w_emit, w_flush_emit, w_taken;
    logic [XLEN-1:0]       w_seq_addr;
    itype_e                w_itype;
    logic [3:0]            w_itype_raw;
    logic [CALL_CNT_W-1:0] w_cnt_nxt;

    trdb_inst_decoder u_dec (
        .inst_i       (r_tc_inst),
        .compressed_i (r_tc_comp),
        .is_branch_o  (w_is_branch),
        .is_jal_o     (w_is_jal),
        .is_jalr_o    (w_is_jalr),
        .is_call_o    (w_is_call),
        .is_ret_o     (w_is_ret),
        .is_xret_o    (w_is_xret)
    );

    // A held tc leaves when its successor retires, on flush, or one cycle after a flush+retire.
    assign w_emit       = r_pend && (r_drain || inst_valid_i || flush_i);
    assign w_flush_emit = r_drain || !inst_valid_i;
    assign w_seq_addr   = r_tc_iaddr + (r_tc_comp ? XLEN'(2) : XLEN'(4));
    assign w_taken      = !w_flush_emit && (iaddr_i != w_seq_addr);
    assign w_itype_raw  = w_itype;

    always_comb begin
        w_itype = NONE;
        if (r_tc_exc)              w_itype = EXC;
        else if (r_tc_int)         w_itype = INT;
        else if (w_is_xret)        w_itype = ERET;
        else if (w_is_branch)      w_itype = w_taken ? T_BR : NT_BR;
        else if (w_is_jalr)        w_itype = (ITYPE_W == 3) ? UNINF_JMP6 :
                                             w_is_call ? UNINF_CALL : w_is_ret ? RET : UNINF_JMP;
        else if (w_is_jal)         w_itype = (ITYPE_W == 3) ? NONE : w_is_call ? INF_CALL : INF_JMP;
    end

    always_comb begin
        w_cnt_nxt = r_call_cnt;
        if (w_emit) begin
            if (w_flush_emit)
                w_cnt_nxt = '0;
            else if ((w_itype == UNINF_CALL || w_itype == INF_CALL) && r_call_cnt != '1)
                w_cnt_nxt = r_call_cnt + CALL_CNT_W'(1);
            else if (w_itype == RET && r_call_cnt != '0)
                w_cnt_nxt = r_call_cnt - CALL_CNT_W'(1);
        end
        if (!IMPLICIT_RET) w_cnt_nxt = '0;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: the pending data is reset along with its valid bit so nothing stale survives reset.
        if (rst_i) begin
            r_pend      <= 1'b0;
            r_drain     <= 1'b0;
            r_tc_iaddr  <= '0;
            r_tc_inst   <= '0;
            r_tc_comp   <= 1'b0;
            r_tc_exc    <= 1'b0;
            r_tc_int    <= 1'b0;
            r_call_cnt  <= '0;
            r_valid     <= 1'b0;
            r_iaddr     <= '0;
            r_itype     <= '0;
            r_ilastsize <= 1'b0;
            r_updiscon  <= 1'b0;
            r_implicit  <= 1'b0;
            r_flushed   <= 1'b0;
        end else begin
            r_valid    <= w_emit;
            r_call_cnt <= w_cnt_nxt;
            if (w_emit) begin
                r_iaddr     <= r_tc_iaddr;
                r_itype     <= w_itype_raw[ITYPE_W-1:0];
                r_ilastsize <= !r_tc_comp;
                r_updiscon  <= is_updiscon(w_itype);
                r_implicit  <= IMPLICIT_RET && (w_itype == RET) && (r_call_cnt != '0);
                r_flushed   <= w_flush_emit;
            end
            if (inst_valid_i) begin
                r_pend     <= 1'b1;
                r_drain    <= flush_i;
                r_tc_iaddr <= iaddr_i;
                r_tc_inst  <= inst_data_i[31:0];
                r_tc_comp  <= compressed_i;
                r_tc_exc   <= exception_i;
                r_tc_int   <= interrupt_i;
            end else if (w_emit) begin
                r_pend  <= 1'b0;
                r_drain <= 1'b0;
            end
        end
    end

    assign valid_o        = r_valid;
    assign iaddr_o        = r_iaddr;
    assign itype_o        = r_itype;
    assign ilastsize_o    = r_ilastsize;
    assign updiscon_o     = r_updiscon;
    assign implicit_ret_o = r_implicit;
    assign flushed_o      = r_flushed;

endmodule

// File: tb/tb_trdb_itype_classifier.sv
// Scoreboard bench: directed E-trace cases plus random retirement streams drive
// ITYPE_W=4 and ITYPE_W=3 instances against a behavioural itype model.
module tb_trdb_itype_classifier;

    logic        clk = 1'b0;
    logic        rst = 1'b1, inst_valid = 1'b0, compressed = 1'b0;
    logic        exception = 1'b0, interrupt = 1'b0, flush = 1'b0;
    logic [31:0] iaddr = '0, inst_data = '0;

    logic        valid4, ilast4, upd4, impl4, fl4;
    logic [31:0] iaddr4;
    logic [3:0]  itype4;
    logic        valid3, ilast3, upd3, impl3, fl3;
    logic [31:0] iaddr3;
    logic [2:0]  itype3;

    trdb_itype_classifier #(.XLEN(32), .ITYPE_W(4), .CALL_CNT_W(4), .IMPLICIT_RET(1'b1)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .inst_valid_i(inst_valid), .iaddr_i(iaddr), .inst_data_i(inst_data),
        .compressed_i(compressed), .exception_i(exception), .interrupt_i(interrupt), .flush_i(flush),
        .valid_o(valid4), .iaddr_o(iaddr4), .itype_o(itype4), .ilastsize_o(ilast4),
        .updiscon_o(upd4), .implicit_ret_o(impl4), .flushed_o(fl4));

    trdb_itype_classifier #(.XLEN(32), .ITYPE_W(3), .CALL_CNT_W(4), .IMPLICIT_RET(1'b1)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .inst_valid_i(inst_valid), .iaddr_i(iaddr), .inst_data_i(inst_data),
        .compressed_i(compressed), .exception_i(exception), .interrupt_i(interrupt), .flush_i(flush),
        .valid_o(valid3), .iaddr_o(iaddr3), .itype_o(itype3), .ilastsize_o(ilast3),
        .updiscon_o(upd3), .implicit_ret_o(impl3), .flushed_o(fl3));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] iaddr;
        logic [3:0]  itype;
        logic        ilast, upd, impl, fl;
    } out_t;
    typedef struct { out_t o; int cyc; } exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] inst; bit c, exc, intr; } ret_t;
    typedef enum { K_OTHER, K_BR, K_JAL, K_JALR, K_XRET } kind_e;

    localparam logic [31:0] ADD = 32'h00B5_0533;

    exp_t q4[$], q3[$];
    int   cyc = 0;
    int   n_pass = 0, n_total = 0;
    bit   m_pend = 0, m_drain = 0;
    ret_t m_tc;
    int   m_cnt4 = 0, m_cnt3 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit lnk(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    // Field-level instruction recognition, straight from the ISA encodings.
    function automatic void decode(input ret_t r, output kind_e k, output logic [4:0] rd, output logic [4:0] rs1);
        logic [15:0] h;
        h = r.inst[15:0];
        k = K_OTHER; rd = 5'd0; rs1 = 5'd0;
        if (r.c) begin
            if (h[1:0] == 2'b01 && h[15:14] == 2'b11) k = K_BR;
            else if (h[1:0] == 2'b01 && h[15:13] == 3'd5) k = K_JAL;
            else if (h[1:0] == 2'b01 && h[15:13] == 3'd1) begin k = K_JAL; rd = 5'd1; end
            else if (h[1:0] == 2'b10 && h[15:13] == 3'd4 && h[6:2] == 5'd0 && h[11:7] != 5'd0) begin
                k = K_JALR; rs1 = h[11:7]; rd = h[12] ? 5'd1 : 5'd0;
            end
        end else begin
            case (r.inst[6:0])
                7'h63: k = K_BR;
                7'h6F: begin k = K_JAL; rd = r.inst[11:7]; end
                7'h67: if (r.inst[14:12] == 3'd0) begin k = K_JALR; rd = r.inst[11:7]; rs1 = r.inst[19:15]; end
                7'h73: if (r.inst == 32'h30200073 || r.inst == 32'h10200073 ||
                           r.inst == 32'h00200073 || r.inst == 32'h7B200073) k = K_XRET;
                default: k = K_OTHER;
            endcase
        end
    endfunction

    task automatic predict(input ret_t tc, input logic [31:0] nc, input bit fl, input int w,
                           inout int cnt, output out_t o);
        kind_e k; logic [4:0] rd, rs1; logic [31:0] seq; int it;
        decode(tc, k, rd, rs1);
        seq = tc.addr + (tc.c ? 32'd2 : 32'd4);
        if (tc.exc) it = 1;
        else if (tc.intr) it = 2;
        else if (k == K_XRET) it = 3;
        else if (k == K_BR) it = (!fl && nc != seq) ? 5 : 4;
        else if (k == K_JALR) it = (w == 3) ? 6 : lnk(rd) ? 8 : (rd == 5'd0 && lnk(rs1)) ? 13 : 10;
        else if (k == K_JAL) it = (w == 3) ? 0 : lnk(rd) ? 9 : 11;
        else it = 0;
        o.iaddr = tc.addr;
        o.itype = 4'(it);
        o.ilast = !tc.c;
        o.upd   = it inside {1, 2, 3, 6, 8, 10, 13};
        o.impl  = (it == 13) && (cnt > 0);
        o.fl    = fl;
        if (fl) cnt = 0;
        else if (it == 8 || it == 9) cnt = (cnt < 15) ? cnt + 1 : 15;
        else if (it == 13 && cnt > 0) cnt = cnt - 1;
    endtask

    function automatic ret_t mk(input logic [31:0] a, input logic [31:0] i, input bit c,
                                input bit e = 1'b0, input bit n = 1'b0);
        ret_t r;
        r.addr = a; r.inst = i; r.c = c; r.exc = e; r.intr = n;
        return r;
    endfunction

    task automatic cycle(input bit r_st, input bit v, input ret_t r, input bit fl);
        bit fe; exp_t e;
        @(posedge clk); #1;
        rst = r_st; inst_valid = v; iaddr = r.addr; inst_data = r.inst;
        compressed = r.c; exception = r.exc; interrupt = r.intr; flush = fl;
        if (r_st) begin
            m_pend = 0; m_drain = 0; m_cnt4 = 0; m_cnt3 = 0;
        end else begin
            if (m_pend && (m_drain || v || fl)) begin
                fe = m_drain || !v;
                e.cyc = cyc + 1;
                predict(m_tc, r.addr, fe, 4, m_cnt4, e.o); q4.push_back(e);
                predict(m_tc, r.addr, fe, 3, m_cnt3, e.o); q3.push_back(e);
                if (!v) begin m_pend = 0; m_drain = 0; end
            end
            if (v) begin m_tc = r; m_pend = 1; m_drain = fl; end
        end
    endtask

    task automatic retire(input logic [31:0] a, input logic [31:0] i, input bit c,
                          input bit e = 1'b0, input bit n = 1'b0);
        cycle(1'b0, 1'b1, mk(a, i, c, e, n), 1'b0);
    endtask
    task automatic idle();       cycle(1'b0, 1'b0, mk('0, '0, 1'b0), 1'b0); endtask
    task automatic flush_idle(); cycle(1'b0, 1'b0, mk('0, '0, 1'b0), 1'b1); endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            default: return 5'($urandom);
        endcase
    endfunction

    task automatic rand_inst(output logic [31:0] i, output bit c);
        c = 1'b0;
        case ($urandom_range(0, 11))
            1: i = {7'($urandom), 10'($urandom), 3'($urandom), 5'($urandom), 7'h63};
            2: i = {20'($urandom), pick_reg(), 7'h6F};
            3: i = {12'($urandom), pick_reg(), 3'b000, pick_reg(), 7'h67};
            4: begin
                case ($urandom_range(0, 3))
                    0: i = 32'h30200073;
                    1: i = 32'h10200073;
                    2: i = 32'h00200073;
                    default: i = 32'h7B200073;
                endcase
            end
            5: begin c = 1'b1; i = {16'h0, 2'b11, 1'($urandom), 11'($urandom), 2'b01}; end
            6: begin c = 1'b1; i = {16'h0, $urandom_range(0, 1) ? 3'b101 : 3'b001, 11'($urandom), 2'b01}; end
            7: begin
                c = 1'b1;
                i = {16'h0, 3'b100, 1'($urandom), $urandom_range(0, 1) ? pick_reg() | 5'd1 : 5'd5, 5'd0, 2'b10};
            end
            8: begin c = 1'b1; i = {16'h0, 3'b000, 11'($urandom), 2'b01}; end
            9: i = {12'($urandom), 5'($urandom), 3'($urandom_range(1, 7)), 5'($urandom), 7'h67};
            10: begin c = 1'b1; i = 32'h0000_9002; end
            default: i = {7'h0, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'h33};
        endcase
    endtask

    always @(negedge clk) begin
        out_t got; exp_t e;
        got = {iaddr4, itype4, ilast4, upd4, impl4, fl4};
        if (valid4 === 1'b1) begin
            if (q4.size() == 0) check("dut4_spurious_valid", 64'd1, 64'd0);
            else begin
                e = q4.pop_front();
                check("dut4_latency", 64'(cyc), 64'(e.cyc));
                check("dut4_output", 64'(got), 64'(e.o));
            end
        end else if (q4.size() != 0 && q4[0].cyc <= cyc) begin
            check("dut4_missing_valid", 64'd0, 64'd1);
            void'(q4.pop_front());
        end
    end

    always @(negedge clk) begin
        out_t got; exp_t e;
        got = {iaddr3, 1'b0, itype3, ilast3, upd3, impl3, fl3};
        if (valid3 === 1'b1) begin
            if (q3.size() == 0) check("dut3_spurious_valid", 64'd1, 64'd0);
            else begin
                e = q3.pop_front();
                check("dut3_latency", 64'(cyc), 64'(e.cyc));
                check("dut3_output", 64'(got), 64'(e.o));
            end
        end else if (q3.size() != 0 && q3[0].cyc <= cyc) begin
            check("dut3_missing_valid", 64'd0, 64'd1);
            void'(q3.pop_front());
        end
    end

    initial begin
        logic [31:0] pc, a, ins;
        bit c, fl;
        repeat (3) cycle(1'b1, 1'b0, mk('0, '0, 1'b0), 1'b0);
        @(negedge clk);
        check("reset_state_dut4", 64'({valid4, iaddr4, itype4, ilast4, upd4, impl4, fl4}), 64'd0);
        check("reset_state_dut3", 64'({valid3, iaddr3, itype3, ilast3, upd3, impl3, fl3}), 64'd0);

        retire(32'h100, 32'h0000_0063, 1'b0);          // BEQ, not taken
        retire(32'h104, ADD, 1'b0);
        retire(32'h200, 32'h0000_E001, 1'b1);          // C.BNEZ, taken
        retire(32'h240, ADD, 1'b0);
        retire(32'h200, 32'h0000_E001, 1'b1);          // C.BNEZ, falls through
        retire(32'h202, ADD, 1'b0);
        retire(32'h300, 32'h0003_00E7, 1'b0);          // JALR ra, 0(x6)
        retire(32'h400, 32'h0000_8067, 1'b0);          // JALR x0, 0(ra)
        retire(32'h304, ADD, 1'b0);
        retire(32'hFFFF_FFFC, 32'h0000_0063, 1'b0);    // BEQ across wrap
        retire(32'h0, ADD, 1'b0);
        retire(32'h10, ADD, 1'b0, 1'b1);               // trapping ADD
        retire(32'h80, ADD, 1'b0, 1'b0, 1'b1);         // interrupt after handler entry
        retire(32'h500, 32'h0000_006F, 1'b0);          // J self-loop
        retire(32'h500, 32'h0000_006F, 1'b0);
        retire(32'h504, ADD, 1'b0);
        flush_idle();
        idle();
        retire(32'h600, 32'h0000_0063, 1'b0);
        cycle(1'b0, 1'b1, mk(32'h700, ADD, 1'b0), 1'b1);
        idle();
        idle();
        retire(32'h800, 32'h0000_00EF, 1'b0);          // JAL ra raises nesting
        retire(32'h900, ADD, 1'b0);
        cycle(1'b1, 1'b0, mk('0, '0, 1'b0), 1'b1);     // reset beats flush with tc pending
        idle();
        retire(32'h1000, 32'h0000_8067, 1'b0);         // return after reset: not implicit
        retire(32'h2000, ADD, 1'b0);
        flush_idle();
        for (int i = 0; i < 16; i++) retire(32'h3000 + 32'(i * 4), 32'h0000_00EF, 1'b0);
        for (int i = 0; i < 16; i++) retire(32'h4000 + 32'(i * 4), 32'h0000_8067, 1'b0);
        retire(32'h5000, ADD, 1'b0);
        flush_idle();
        idle();

        pc = 32'h8000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 15) begin
                if (m_pend && !m_drain && $urandom_range(0, 4) == 0) flush_idle();
                else idle();
            end else begin
                rand_inst(ins, c);
                a = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF_FFFE) : pc;
                fl = m_pend && !m_drain && ($urandom_range(0, 99) < 3);
                cycle(1'b0, 1'b1, mk(a, ins, c, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4), fl);
                pc = a + (c ? 32'd2 : 32'd4);
            end
        end
        if (m_pend && !m_drain) flush_idle();
        repeat (4) idle();
        @(negedge clk);
        check("dut4_queue_drained", 64'(q4.size()), 64'd0);
        check("dut3_queue_drained", 64'(q3.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
